// File: rtl/piezo_tune_seq.sv
// Tune sequencer for the piezo frequency counter: walks a small note ROM and
// drives note_per/clr with per-note play time and a fixed silent gap after each note.
module piezo_tune_seq #(
  parameter int TICK_CYC = 4194304,
  parameter int GAP_CYC  = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  tune_sel,
  input  logic        abort,
  output logic [14:0] note_per,
  output logic        clr,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | silent, waiting for start
  // LOAD  | one clk: fetch ROM entry, latch note_per/dur/last
  // PLAY  | piezo toggling for dur*TICK_CYC clks
  // GAP   | forced silence for GAP_CYC clks
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  localparam logic [25:0] TICK_W   = 26'(TICK_CYC);
  localparam logic [18:0] GAP_TERM = 19'(GAP_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  addr, addr_nxt;
  logic [2:0]  dur;
  logic        last;
  logic [25:0] dur_cnt, dur_cnt_nxt;
  logic [18:0] gap_cnt, gap_cnt_nxt;
  logic        done_nxt;
  logic        load;
  logic [25:0] dur_term;

  logic [18:0] rom_word;
  logic [14:0] rom_per;
  logic [2:0]  rom_dur;
  logic        rom_last;

  // ROM entry = {per[14:0], dur[2:0], last}
  always_comb begin
    rom_word = 19'd0;
    case (addr)
      4'd0:    rom_word = {15'h7C90, 3'd1, 1'b0};
      4'd1:    rom_word = {15'h5D51, 3'd1, 1'b0};
      4'd2:    rom_word = {15'h4A11, 3'd1, 1'b0};
      4'd3:    rom_word = {15'h3E48, 3'd3, 1'b1};
      4'd4:    rom_word = {15'h6000, 3'd2, 1'b1};
      4'd8:    rom_word = {15'h7000, 3'd1, 1'b0};
      4'd9:    rom_word = {15'h6000, 3'd1, 1'b1};
      4'd12:   rom_word = {15'h0000, 3'd0, 1'b1};
      default: rom_word = 19'd0;
    endcase
  end

  assign rom_per  = rom_word[18:4];
  assign rom_dur  = rom_word[3:1];
  assign rom_last = rom_word[0];

  // dur<=7 and TICK_CYC<=2^22 keeps the product inside 26 bits
  assign dur_term = 26'(dur) * TICK_W - 26'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    dur_cnt_nxt = dur_cnt;
    gap_cnt_nxt = gap_cnt;
    done_nxt    = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          addr_nxt  = {tune_sel, 2'b00};
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (rom_dur != 3'd0) begin
          state_nxt = PLAY;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      PLAY: begin
        if (dur_cnt == dur_term) begin
          dur_cnt_nxt = 26'd0;
          state_nxt   = GAP;
        end else begin
          dur_cnt_nxt = dur_cnt + 26'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_TERM) begin
          gap_cnt_nxt = 19'd0;
          if (last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt  = addr + 4'd1;
            state_nxt = LOAD;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + 19'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including a pending LOAD fetch
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      done_nxt    = 1'b0;
      dur_cnt_nxt = 26'd0;
      gap_cnt_nxt = 19'd0;
      load        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= 4'd0;
      dur      <= 3'd0;
      last     <= 1'b0;
      note_per <= 15'd0;
      dur_cnt  <= 26'd0;
      gap_cnt  <= 19'd0;
      done     <= 1'b0;
    end else begin
      addr    <= addr_nxt;
      dur_cnt <= dur_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      done    <= done_nxt;
      if (load) begin
        note_per <= rom_per;
        dur      <= rom_dur;
        last     <= rom_last;
      end
    end
  end

  assign clr  = (state != PLAY);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Directed bench for piezo_tune_seq: expected note/gap/done events are queued
// with each request and matched against what a negedge monitor observes.
module tb_piezo_tune_seq;

  localparam int TICK = 100;
  localparam int GAPC = 10;
  localparam int EV_NOTE = 0;
  localparam int EV_GAP  = 1;
  localparam int EV_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  tune_sel = 2'd0;
  logic        abort = 1'b0;
  logic [14:0] note_per;
  logic        clr;
  logic        busy;
  logic        done;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  passed = 0;

  logic clr_p = 1'b1;
  logic busy_p = 1'b0;
  logic done_p = 1'b0;
  int   low_cnt = 0;
  int   high_cnt = 0;
  int   busy_cnt = 0;
  bit   note_seen = 1'b0;

  piezo_tune_seq #(.TICK_CYC(TICK), .GAP_CYC(GAPC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tune_sel (tune_sel),
    .abort    (abort),
    .note_per (note_per),
    .clr      (clr),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int a, input int b);
    ev_t e;
    total++;
    assert (exp_q.size() != 0) passed++;
    else $error("FAIL unexpected_event observed kind=%0d value=0x%0h len=%0d expected=none", kind, a, b);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_value", a, e.a);
      chk("event_len", b, e.b);
    end
  endtask

  task automatic kick(input logic [1:0] sel);
    @(negedge clk);
    start = 1'b1;
    tune_sel = sel;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Monitor: clr-low windows become NOTE events, in-tune silences GAP events
  initial begin
    forever begin
      @(negedge clk);
      if (busy && !busy_p) begin
        busy_cnt = 0;
        note_seen = 1'b0;
        high_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (!clr) begin
        if (clr_p && note_seen) observe(EV_GAP, high_cnt, 0);
        low_cnt++;
        high_cnt = 0;
      end else begin
        if (!clr_p) begin
          observe(EV_NOTE, note_per, low_cnt);
          low_cnt = 0;
          note_seen = 1'b1;
          high_cnt = 0;
        end
        if (note_seen && busy) high_cnt++;
      end
      if (done) begin
        chk("done_single_clk", done_p, 1'b0);
        observe(EV_DONE, busy_cnt, 0);
      end
      clr_p = clr;
      busy_p = busy;
      done_p = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values
    #12;
    chk("rst_clr", clr, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_note_per", note_per, 15'h0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle 50 clks
    repeat (50) @(negedge clk);
    chk("idle_clr", clr, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_note_per", note_per, 15'h0);

    // tune 1 with latency checks
    push(EV_NOTE, 32'h6000, 200);
    push(EV_DONE, 211, 0);
    @(negedge clk);
    start = 1'b1;
    tune_sel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_busy", busy, 1'b1);
    chk("lat_clr_load", clr, 1'b1);
    @(negedge clk);
    chk("lat_clr_play", clr, 1'b0);
    chk("t1_note_per", note_per, 15'h6000);
    drain("t1_drain", 400);

    // tune 0 fanfare
    push(EV_NOTE, 32'h7C90, 100);
    push(EV_GAP, 11, 0);
    push(EV_NOTE, 32'h5D51, 100);
    push(EV_GAP, 11, 0);
    push(EV_NOTE, 32'h4A11, 100);
    push(EV_GAP, 11, 0);
    push(EV_NOTE, 32'h3E48, 300);
    push(EV_DONE, 644, 0);
    kick(2'd0);
    drain("t0_drain", 1000);

    // abort in the 40th clk of note 2
    push(EV_NOTE, 32'h7C90, 100);
    push(EV_GAP, 11, 0);
    push(EV_NOTE, 32'h5D51, 40);
    kick(2'd0);
    n = 0;
    while (!(clr == 1'b0 && note_per == 15'h5D51) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_note2_reached", n < 500, 1'b1);
    repeat (39) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clr", clr, 1'b1);
    chk("abort_busy", busy, 1'b0);
    drain("abort_drain", 20);
    repeat (20) @(negedge clk);

    // tune 2 after abort
    push(EV_NOTE, 32'h7000, 100);
    push(EV_GAP, 11, 0);
    push(EV_NOTE, 32'h6000, 100);
    push(EV_DONE, 222, 0);
    kick(2'd2);
    drain("t2_drain", 500);

    // empty tune 3, then start in the done clk
    push(EV_DONE, 1, 0);
    push(EV_NOTE, 32'h6000, 200);
    push(EV_DONE, 211, 0);
    kick(2'd3);
    chk("t3_busy_load", busy, 1'b1);
    @(negedge clk);
    chk("t3_done", done, 1'b1);
    chk("t3_busy_idle", busy, 1'b0);
    start = 1'b1;
    tune_sel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_busy", busy, 1'b1);
    chk("t3_note_per", note_per, 15'h0);
    drain("t3_drain", 400);

    // start re-pulsed while busy is ignored
    push(EV_NOTE, 32'h6000, 200);
    push(EV_DONE, 211, 0);
    kick(2'd1);
    repeat (50) @(negedge clk);
    start = 1'b1;
    tune_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    chk("restart_note_per", note_per, 15'h6000);
    drain("restart_drain", 400);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_clr", clr, 1'b1);
    repeat (5) @(negedge clk);

    // async reset during the first gap
    push(EV_NOTE, 32'h7C90, 100);
    kick(2'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_note_seen", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clr", clr, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_note_per", note_per, 15'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_stays_idle", busy, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
